cp0_exc_ctrl: RTL

Exception/ERET sequencer and the write-side initiator for the CP0 register file. It sits between the pipeline's commit stage and the single-write-port CP0 register file. On an exception it updates BadVAddr, Cause, EPC and Status with a series of read-modify-write accesses, then pulses a PC redirect to the exception vector. On ERET it reads EPC, clears Status.EXL and redirects. When idle it forwards pipeline MTC0 writes straight through.

---
 rtl/cp0_exc_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cp0_exc_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_exc_ctrl
//
// Exception / ERET sequencer and the write-side initiator for the CP0 register
// file. Sits between the pipeline commit stage and a single-write-port CP0
// register file.
//
//  * Exception: a chain of read-modify-write accesses updates BadVAddr (8),
//    Cause (13), EPC (14) and Status (12), then a one-cycle PC redirect to
//    EXC_VECTOR is pulsed.
//  * ERET: EPC is read into the redirect target, Status.EXL is cleared, then
//    the redirect is pulsed.
//  * Idle: pipeline MTC0 writes are forwarded combinationally to the write
//    port in the same cycle.
//
// Optional feature macro: CP0_BADVADDR_EN
//   defined   - W_BADV state present; BadVAddr is written when
//               exc_badv_valid accompanies the exception.
//   undefined - W_BADV removed; exc_badv_valid / exc_badvaddr are ignored and
//               reg 8 is never written by the sequencer.
//
// Ports
//   clk             in   system clock, rising edge
//   rst             in   asynchronous reset, active-low
//   exc_valid       in   exception at commit (single-cycle request)
//   exc_code        in   [4:0]  ExcCode
//   exc_pc          in   [31:0] PC of faulting instruction
//   exc_bd          in   faulting instruction is in a delay slot
//   exc_badv_valid  in   exc_badvaddr is meaningful
//   exc_badvaddr    in   [31:0] faulting address
//   eret_valid      in   ERET at commit
//   mtc0_valid      in   MTC0 at commit
//   mtc0_addr       in   [4:0]  MTC0 target register
//   mtc0_sel        in   [2:0]  MTC0 target select
//   mtc0_wdata      in   [31:0] MTC0 write data
//   busy            out  sequencer not idle; pipeline must hold commit
//   redirect_valid  out  one-cycle PC redirect pulse
//   redirect_pc     out  [31:0] redirect target
//   cp0_waddr       out  [4:0]  CP0 write address
//   cp0_sel         out  [2:0]  CP0 select
//   cp0_wen         out  CP0 write enable
//   cp0_wdata       out  [31:0] CP0 write data
//   cp0_raddr       out  [4:0]  CP0 read address
//   cp0_rdata       in   [31:0] CP0 read data (combinational)
// -----------------------------------------------------------------------------
module cp0_exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'hbfc00380
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_valid,
   input  logic [4:0]  exc_code,
   input  logic [31:0] exc_pc,
   input  logic        exc_bd,
   input  logic        exc_badv_valid,
   input  logic [31:0] exc_badvaddr,
   input  logic        eret_valid,
   input  logic        mtc0_valid,
   input  logic [4:0]  mtc0_addr,
   input  logic [2:0]  mtc0_sel,
   input  logic [31:0] mtc0_wdata,
   output logic        busy,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [4:0]  cp0_waddr,
   output logic [2:0]  cp0_sel,
   output logic        cp0_wen,
   output logic [31:0] cp0_wdata,
   output logic [4:0]  cp0_raddr,
   input  logic [31:0] cp0_rdata
);

   localparam logic [4:0] REG_BADV   = 5'd8;
   localparam logic [4:0] REG_STATUS = 5'd12;
   localparam logic [4:0] REG_CAUSE  = 5'd13;
   localparam logic [4:0] REG_EPC    = 5'd14;

   typedef enum logic [2:0] {
      IDLE,
`ifdef CP0_BADVADDR_EN
      W_BADV,
`endif
      W_CAUSE,
      W_EPC,
      W_STATUS,
      E_EPC,
      E_STATUS,
      REDIRECT
   } state_t;

   state_t      state;
   logic        old_exl;
   logic [31:0] redirect_pc_q;

   // Exception context captured when the exception is accepted
   logic [4:0]  code_q;
   logic [31:0] pc_q;
   logic        bd_q;
`ifdef CP0_BADVADDR_EN
   logic [31:0] badv_q;
`else
   logic        unused_badv;
   assign unused_badv = ^{exc_badv_valid, exc_badvaddr};
`endif

   // Cause update: ExcCode always replaced; BD replaced only for a first-level
   // exception (EXL was clear), otherwise the original BD is preserved.
   function automatic logic [31:0] merge_cause(input logic [31:0] cur,
                                               input logic [4:0]  code,
                                               input logic        bd,
                                               input logic        keep_bd);
      logic [31:0] r;
      r      = cur;
      r[6:2] = code;
      if (!keep_bd)
         r[31] = bd;
      return r;
   endfunction

   // EPC points at the branch when the fault is in its delay slot
   function automatic logic [31:0] epc_value(input logic [31:0] pc,
                                             input logic        bd);
      return bd ? (pc - 32'd4) : pc;
   endfunction

   // Control state: FSM, old EXL snapshot, redirect target
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         old_exl       <= 1'b0;
         redirect_pc_q <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (exc_valid) begin
                  // cp0_raddr points at Status while idle
                  old_exl <= cp0_rdata[1];
`ifdef CP0_BADVADDR_EN
                  state   <= exc_badv_valid ? W_BADV : W_CAUSE;
`else
                  state   <= W_CAUSE;
`endif
               end else if (eret_valid) begin
                  state <= E_EPC;
               end
            end
`ifdef CP0_BADVADDR_EN
            W_BADV:   state <= W_CAUSE;
`endif
            W_CAUSE:  state <= old_exl ? W_STATUS : W_EPC;
            W_EPC:    state <= W_STATUS;
            W_STATUS: begin
               redirect_pc_q <= EXC_VECTOR;
               state         <= REDIRECT;
            end
            E_EPC: begin
               redirect_pc_q <= cp0_rdata;
               state         <= E_STATUS;
            end
            E_STATUS: state <= REDIRECT;
            REDIRECT: state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

   // Exception context registers carry data only and need no reset
   always_ff @(posedge clk) begin
      if (state == IDLE && exc_valid) begin
         code_q <= exc_code;
         pc_q   <= exc_pc;
         bd_q   <= exc_bd;
`ifdef CP0_BADVADDR_EN
         badv_q <= exc_badvaddr;
`endif
      end
   end

   // CP0 port drive. Reads and the dependent write data are combinational
   // within a state; the write lands on the edge that leaves the state.
   // Everything is held at zero while reset is asserted.
   always_comb begin
      cp0_wen   = 1'b0;
      cp0_waddr = 5'd0;
      cp0_sel   = 3'd0;
      cp0_wdata = 32'd0;
      cp0_raddr = 5'd0;
      if (rst) begin
         case (state)
            IDLE: begin
               cp0_raddr = REG_STATUS;
               if (!exc_valid && !eret_valid && mtc0_valid) begin
                  cp0_wen   = 1'b1;
                  cp0_waddr = mtc0_addr;
                  cp0_sel   = mtc0_sel;
                  cp0_wdata = mtc0_wdata;
               end
            end
`ifdef CP0_BADVADDR_EN
            W_BADV: begin
               cp0_wen   = 1'b1;
               cp0_waddr = REG_BADV;
               cp0_wdata = badv_q;
            end
`endif
            W_CAUSE: begin
               cp0_raddr = REG_CAUSE;
               cp0_wen   = 1'b1;
               cp0_waddr = REG_CAUSE;
               cp0_wdata = merge_cause(cp0_rdata, code_q, bd_q, old_exl);
            end
            W_EPC: begin
               cp0_wen   = 1'b1;
               cp0_waddr = REG_EPC;
               cp0_wdata = epc_value(pc_q, bd_q);
            end
            W_STATUS: begin
               cp0_raddr = REG_STATUS;
               cp0_wen   = 1'b1;
               cp0_waddr = REG_STATUS;
               cp0_wdata = cp0_rdata | 32'h0000_0002;
            end
            E_EPC: begin
               cp0_raddr = REG_EPC;
            end
            E_STATUS: begin
               cp0_raddr = REG_STATUS;
               cp0_wen   = 1'b1;
               cp0_waddr = REG_STATUS;
               cp0_wdata = cp0_rdata & ~32'h0000_0002;
            end
            default: ;
         endcase
      end
   end

   assign busy           = (state != IDLE);
   assign redirect_valid = (state == REDIRECT);
   assign redirect_pc    = redirect_pc_q;

endmodule
